// File: rtl/vote_pkg.sv
// Shared definitions for the four-candidate voting machine: state encodings,
// candidate indices and ballot classification helpers.
package vote_pkg;

   localparam int NUM_CAND = 4;
   localparam int CAND_A   = 0;
   localparam int CAND_B   = 1;
   localparam int CAND_C   = 2;
   localparam int CAND_D   = 3;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_READY   = 3'd1,
      ST_ARMED   = 3'd2,
      ST_RELEASE = 3'd3,
      ST_CLOSED  = 3'd4
   } state_t;

   // A vote is valid only when exactly one candidate button is down.
   function automatic logic is_onehot(input logic [NUM_CAND-1:0] v);
      return (v != '0) && ((v & (v - NUM_CAND'(1))) == '0);
   endfunction

endpackage

// File: rtl/vote_timer.sv
// Voter inactivity timer: loads TIMEOUT on admission and counts down while armed.
// o_expired marks the final permitted cycle, when the count is 1.
module vote_timer #(
   parameter int TIMEOUT = 1000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_load,
   input  logic i_en,
   output logic o_expired
);

   localparam int TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= TW'(TIMEOUT);
      end else if (i_en && (r_count != '0)) begin
         r_count <= r_count - TW'(1);
      end
   end

   assign o_expired = (r_count == TW'(1));

endmodule

// File: rtl/vote_controller.sv
// Session controller: admits one voter at a time, turns the single accepted
// button press into a one-cycle increment pulse, and keeps poll statistics.
module vote_controller
   import vote_pkg::*;
#(
   parameter int CNT_W   = 21,
   parameter int TIMEOUT = 1000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                open_poll,
   input  logic                close_poll,
   input  logic                voter_req,
   input  logic [NUM_CAND-1:0] btn,
   output logic                voter_ack,
   output logic [NUM_CAND-1:0] inc,
   output logic                clr_counts,
   output logic [CNT_W-1:0]    total_votes,
   output logic [CNT_W-1:0]    spoiled,
   output logic [CNT_W-1:0]    abandoned,
   output logic [2:0]          state,
   output logic                result_valid
);

   localparam logic [CNT_W-1:0] CNT_MAX    = '1;
   localparam logic [CNT_W-1:0] CNT_MAX_M1 = CNT_MAX - CNT_W'(1);

   state_t              r_state;
   logic [NUM_CAND-1:0] r_inc;
   logic                r_ack;
   logic                r_clr;
   logic                r_result_valid;
   logic                r_close_pend;
   logic [CNT_W-1:0]    r_total;
   logic [CNT_W-1:0]    r_spoiled;
   logic [CNT_W-1:0]    r_abandoned;

   logic w_btn_idle;
   logic w_load;
   logic w_en;
   logic w_expired;

   assign w_btn_idle = (btn == '0);
   assign w_load     = (r_state == ST_READY) && !close_poll && voter_req && w_btn_idle;
   assign w_en       = (r_state == ST_ARMED);

   vote_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk       (clk),
      .rst_n     (rst),
      .i_load    (w_load),
      .i_en      (w_en),
      .o_expired (w_expired)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state        <= ST_IDLE;
         r_inc          <= '0;
         r_ack          <= 1'b0;
         r_clr          <= 1'b0;
         r_result_valid <= 1'b0;
         r_close_pend   <= 1'b0;
         r_total        <= '0;
         r_spoiled      <= '0;
         r_abandoned    <= '0;
      end else begin
         r_inc <= '0;
         r_ack <= 1'b0;
         r_clr <= 1'b0;
         case (r_state)
            ST_IDLE, ST_CLOSED: begin
               if (open_poll) begin
                  r_state        <= ST_READY;
                  r_clr          <= 1'b1;
                  r_result_valid <= 1'b0;
                  r_close_pend   <= 1'b0;
                  r_total        <= '0;
                  r_spoiled      <= '0;
                  r_abandoned    <= '0;
               end
            end
            ST_READY: begin
               if (close_poll) begin
                  r_state        <= ST_CLOSED;
                  r_result_valid <= 1'b1;
               end else if (voter_req && w_btn_idle) begin
                  r_state <= ST_ARMED;
                  r_ack   <= 1'b1;
               end
            end
            ST_ARMED: begin
               if (close_poll) begin
                  r_close_pend <= 1'b1;
               end
               // A press wins over a timeout landing on the same cycle.
               if (is_onehot(btn)) begin
                  r_inc   <= btn;
                  r_total <= r_total + CNT_W'(1);
                  if (r_total == CNT_MAX_M1) begin
                     r_close_pend <= 1'b1;
                  end
                  r_state <= ST_RELEASE;
               end else if (!w_btn_idle) begin
                  if (r_spoiled != CNT_MAX) begin
                     r_spoiled <= r_spoiled + CNT_W'(1);
                  end
                  r_state <= ST_RELEASE;
               end else if (w_expired) begin
                  if (r_abandoned != CNT_MAX) begin
                     r_abandoned <= r_abandoned + CNT_W'(1);
                  end
                  r_state <= ST_RELEASE;
               end
            end
            ST_RELEASE: begin
               if (w_btn_idle) begin
                  if (r_close_pend) begin
                     r_state        <= ST_CLOSED;
                     r_result_valid <= 1'b1;
                     r_close_pend   <= 1'b0;
                  end else begin
                     r_state <= ST_READY;
                  end
               end
            end
            default: begin
               r_state        <= ST_IDLE;
               r_result_valid <= 1'b0;
            end
         endcase
      end
   end

   assign voter_ack    = r_ack;
   assign inc          = r_inc;
   assign clr_counts   = r_clr;
   assign total_votes  = r_total;
   assign spoiled      = r_spoiled;
   assign abandoned    = r_abandoned;
   assign state        = r_state;
   assign result_valid = r_result_valid;

endmodule
